gate_test_seq: RTL and testbench
================================

# gate_test_seq

Sequencer that exercises a two-input AND/OR gate pair (`and_or1`-style unit with inputs `x1`, `x2` and outputs `and2`, `or2`). On a start request it walks all four input combinations and holds each for a programmable settle time. It samples the unit's outputs, compares them against the expected AND/OR results and reports a per-vector fail mask, a mismatch count and a pass flag. It sits between the lab-board control logic and the gate unit under test, and is the only driver of the unit's inputs.

## Interface

Parameters:
- `SETTLE`, default 2: cycles each vector is held before sampling. Legal range is 1 to 255; 0 is illegal.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: run request, sampled only in IDLE.
- `and2`  in  1: AND output from the gate unit.
- `or2`  in  1: OR output from the gate unit.
- `x1`  out  1: gate unit input 1 (registered).
- `x2`  out  1: gate unit input 2 (registered).
- `busy`  out  1: high while a run is in progress.
- `done`  out  1: one-cycle pulse when a run completes.
- `pass`  out  1: high when the last completed run had zero mismatches.
- `fail_mask`  out  4: bit i is set when vector i mismatched on either output.
- `err_cnt`  out  4: total mismatched output bits in the current or last run, range 0..8.

## Operation

- Vector index `v` runs 0..3 and drives `x1 = v[0]`, `x2 = v[1]`. Order of (x1,x2): (0,0), (1,0), (0,1), (1,1).
- Expected values are computed from the vector register, not from the sampled outputs: `exp_and = v[0] & v[1]`, `exp_or = v[0] | v[1]`.
- States:
  - IDLE: `x1 = x2 = 0`, `busy = 0`. Moves to RUN when `start = 1`.
  - RUN: `busy = 1`. A settle counter counts from 0 to SETTLE-1.
- In RUN, on the edge where the counter equals SETTLE-1:
  - Sample `and2` and `or2` and compare with the expected values.
  - `err_cnt` increments by the number of mismatched bits (0, 1 or 2) and saturates at 8.
  - `fail_mask[v]` is set if the mismatch count for that vector is nonzero.
  - If `v < 3`: `v` increments, the counter clears, and the new vector drives on the same edge.
  - If `v = 3`: go to IDLE, set `done = 1` for one cycle, load `pass = (final err_cnt == 0)`, and drive `x1 = x2 = 0`.
- On the edge where start is accepted: `fail_mask`, `err_cnt` and `pass` clear to 0, `v = 0`, the counter clears to 0, and `busy` rises.
- Between runs, `fail_mask`, `err_cnt` and `pass` hold their values until the next start is accepted.
- `start` is ignored while in RUN, including on the final sample edge.
- `start` held continuously high is accepted again on the first IDLE cycle, which gives back-to-back runs.

## Timing

- Reset values (after any edge with `rst = 1`):
  - `x1 = x2 = 0`, `busy = 0`, `done = 0`, `pass = 0`, `fail_mask = 0`, `err_cnt = 0`.
  - State IDLE, `v = 0`, counter 0.
- `rst` has priority over every other event, including a start acceptance or final sample on the same edge.
- Reset during RUN aborts the run. Partial results are discarded and `done` is not pulsed.
- Start accepted at edge E0:
  - Vector k is driven from edge E0 + k·SETTLE.
  - Vector k is sampled at edge E0 + (k+1)·SETTLE.
  - `done = 1` and `busy = 0` in the cycle following edge E0 + 4·SETTLE.
- Run length is 4·SETTLE cycles of `busy`. The earliest next accept is edge E0 + 4·SETTLE + 1.
- `done` and `pass` change on the same edge; `pass` stays valid after `done` falls.
- `fail_mask` and `err_cnt` update live at each sample edge during RUN.
- Inputs `and2`/`or2` are sampled only at sample edges. Glitches in other cycles have no effect.

## Test plan

- Reset: hold `rst = 1` for 2 cycles, with `start = 1` throughout.
  - All outputs must be at reset values and `busy` must stay 0.
- Good unit connected, SETTLE = 2, one-cycle `start` pulse at E0:
  - (x1,x2) must be (0,0), (1,0), (0,1), (1,1), each held for 2 cycles.
  - `busy` high for 8 cycles; `done` pulses after E0+8.
  - Results: `pass = 1`, `fail_mask = 4'b0000`, `err_cnt = 0`.
- Faulty units, SETTLE = 1:
  - `and2` stuck at 0: `fail_mask = 4'b1000`, `err_cnt = 1`, `pass = 0`.
  - `or2` stuck at 1: `fail_mask = 4'b0001`, `err_cnt = 1`.
  - Outputs swapped: `fail_mask = 4'b0110`, `err_cnt = 4`.
- Start handling:
  - Extra `start` pulses during RUN produce no restart and no extra cycles.
  - `start` held high produces a second run beginning one cycle after `done`.
  - The second run's accept edge clears the previous `fail_mask` and `err_cnt`.
- Reset mid-run:
  - Assert `rst` for one cycle while vector 2 is driven.
  - The next cycle must show reset values with no `done`.
  - A following `start` must run the full four-vector sequence with correct results.

Source files
------------

// File: rtl/gate_test_seq.sv
// Purpose : drives all four (x1,x2) combinations into an AND/OR gate unit, holds each
//           for SETTLE cycles, samples and2/or2 and reports fail_mask, err_cnt and pass.
// Latency : a run is 4*SETTLE cycles from the start accept edge; done pulses the cycle after.
// Ports   : clk/rst (sync, active-high), start request; and2/or2 from the unit;
//           x1/x2 to the unit; busy, done, pass, fail_mask[3:0], err_cnt[3:0] status.
module gate_test_seq #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       and2,
    input  logic       or2,
    output logic       x1,
    output logic       x2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [3:0] err_cnt
);

    localparam logic [7:0] LAST = 8'(SETTLE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] v_q, v_d;
    logic [7:0] cnt_q, cnt_d;
    logic       x1_q, x1_d;
    logic       x2_q, x2_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] mask_q, mask_d;
    logic [3:0] err_q, err_d;

    // Expected results come from the vector register, never from the sampled outputs.
    logic       exp_and, exp_or;
    logic       mm_and, mm_or;
    logic [1:0] mm_cnt;
    logic [4:0] err_sum;
    logic [3:0] err_sat;
    logic [1:0] v_next;

    always_comb begin
        exp_and = v_q[0] & v_q[1];
        exp_or  = v_q[0] | v_q[1];
        mm_and  = and2 ^ exp_and;
        mm_or   = or2 ^ exp_or;
        mm_cnt  = {1'b0, mm_and} + {1'b0, mm_or};
        err_sum = {1'b0, err_q} + {3'b000, mm_cnt};
        err_sat = (err_sum > 5'd8) ? 4'd8 : err_sum[3:0];
        v_next  = v_q + 2'd1;
    end

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        mask_d  = mask_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                x1_d = 1'b0;
                x2_d = 1'b0;
                if (start) begin
                    state_d = RUN;
                    v_d     = 2'd0;
                    cnt_d   = 8'd0;
                    mask_d  = 4'd0;
                    err_d   = 4'd0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                if (cnt_q == LAST) begin
                    // Sample edge: score this vector, then advance or finish.
                    err_d       = err_sat;
                    mask_d[v_q] = mask_q[v_q] | (mm_cnt != 2'd0);
                    cnt_d       = 8'd0;
                    if (v_q == 2'd3) begin
                        state_d = IDLE;
                        v_d     = 2'd0;
                        x1_d    = 1'b0;
                        x2_d    = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_sat == 4'd0);
                    end else begin
                        v_d  = v_next;
                        x1_d = v_next[0];
                        x2_d = v_next[1];
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            v_q     <= 2'd0;
            cnt_q   <= 8'd0;
            x1_q    <= 1'b0;
            x2_q    <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            mask_q  <= 4'd0;
            err_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
        end
    end

    assign x1        = x1_q;
    assign x2        = x2_q;
    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_mask = mask_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_gate_test_seq.sv
module tb_gate_test_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: SETTLE=2; instance B: SETTLE=1. Each drives its own gate model.
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [1:0] mode_a = 2'd0, mode_b = 2'd0;
    logic       x1_a, x2_a, and_a, or_a, busy_a, done_a, pass_a;
    logic       x1_b, x2_b, and_b, or_b, busy_b, done_b, pass_b;
    logic [3:0] mask_a, err_a, mask_b, err_b;

    int n_vec = 0;
    int n_err = 0;

    // Gate unit model: 0 good, 1 and2 stuck-at-0, 2 or2 stuck-at-1, 3 outputs swapped.
    function automatic logic [1:0] gate(input logic [1:0] m, input logic a, input logic b);
        case (m)
            2'd1:    gate = {1'b0, a | b};
            2'd2:    gate = {a & b, 1'b1};
            2'd3:    gate = {a | b, a & b};
            default: gate = {a & b, a | b};
        endcase
    endfunction

    assign {and_a, or_a} = gate(mode_a, x1_a, x2_a);
    assign {and_b, or_b} = gate(mode_b, x1_b, x2_b);

    gate_test_seq #(.SETTLE(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .and2(and_a), .or2(or_a),
        .x1(x1_a), .x2(x2_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .fail_mask(mask_a), .err_cnt(err_a)
    );

    gate_test_seq #(.SETTLE(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .and2(and_b), .or2(or_b),
        .x1(x1_b), .x2(x2_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .fail_mask(mask_b), .err_cnt(err_b)
    );

    task automatic test_reset();
        rst = 1'b1; start_a = 1'b1; start_b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); @(negedge clk);
            n_vec++;
            if ({busy_a, done_a, pass_a, x1_a, x2_a, mask_a, err_a} !== 13'd0) begin
                n_err++;
                $display("FAIL reset_a cyc%0d: got busy=%b done=%b pass=%b x=%b%b mask=%b err=%0d want all 0",
                         i, busy_a, done_a, pass_a, x1_a, x2_a, mask_a, err_a);
            end
            n_vec++;
            if ({busy_b, done_b, pass_b, x1_b, x2_b, mask_b, err_b} !== 13'd0) begin
                n_err++;
                $display("FAIL reset_b cyc%0d: got busy=%b done=%b pass=%b mask=%b err=%0d want all 0",
                         i, busy_b, done_b, pass_b, mask_b, err_b);
            end
        end
        start_a = 1'b0; start_b = 1'b0;
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        n_vec++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: got busy_a=%b busy_b=%b want 0 0", busy_a, busy_b);
        end
    endtask

    // Good run on instance A; extra start pulses during RUN when 'poke' is set.
    task automatic test_good_run(input bit poke, input string tag);
        mode_a = 2'd0;
        start_a = 1'b1;
        @(posedge clk); @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] iv;
            logic [1:0] kv;
            iv = 3'(i);
            kv = iv[2:1];
            n_vec++;
            if ({busy_a, done_a, x1_a, x2_a} !== {1'b1, 1'b0, kv[0], kv[1]}) begin
                n_err++;
                $display("FAIL %s cyc%0d: got busy=%b done=%b x1=%b x2=%b want 1 0 %b %b",
                         tag, i, busy_a, done_a, x1_a, x2_a, kv[0], kv[1]);
            end
            start_a = poke && (i == 2 || i == 7);
            @(negedge clk);
        end
        start_a = 1'b0;
        n_vec++;
        if ({done_a, busy_a, pass_a, x1_a, x2_a, mask_a, err_a} !== {3'b101, 2'b00, 4'd0, 4'd0}) begin
            n_err++;
            $display("FAIL %s_end: got done=%b busy=%b pass=%b x=%b%b mask=%b err=%0d want 1 0 1 00 0000 0",
                     tag, done_a, busy_a, pass_a, x1_a, x2_a, mask_a, err_a);
        end
        @(negedge clk);
        n_vec++;
        if ({done_a, busy_a, pass_a} !== 3'b001) begin
            n_err++;
            $display("FAIL %s_after: got done=%b busy=%b pass=%b want 0 0 1", tag, done_a, busy_a, pass_a);
        end
    endtask

    task automatic test_fault(input logic [1:0] m, input logic [3:0] xm, input logic [3:0] xe,
                              input logic xp, input string tag);
        int cyc;
        mode_b = m;
        start_b = 1'b1;
        @(posedge clk); @(negedge clk);
        start_b = 1'b0;
        cyc = 0;
        while (!done_b && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (cyc !== 4) begin
            n_err++;
            $display("FAIL %s_len: done after %0d cycles want 4", tag, cyc);
        end
        n_vec++;
        if ({mask_b, err_b, pass_b} !== {xm, xe, xp}) begin
            n_err++;
            $display("FAIL %s: got mask=%b err=%0d pass=%b want mask=%b err=%0d pass=%b",
                     tag, mask_b, err_b, pass_b, xm, xe, xp);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        mode_b = 2'd3;
        start_b = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({done_b, busy_b, pass_b, mask_b, err_b} !== {3'b100, 4'b0110, 4'd4}) begin
            n_err++;
            $display("FAIL b2b_first: got done=%b busy=%b pass=%b mask=%b err=%0d want 1 0 0 0110 4",
                     done_b, busy_b, pass_b, mask_b, err_b);
        end
        @(posedge clk); @(negedge clk);
        n_vec++;
        if ({done_b, busy_b, pass_b, mask_b, err_b} !== {3'b010, 4'd0, 4'd0}) begin
            n_err++;
            $display("FAIL b2b_restart: got done=%b busy=%b pass=%b mask=%b err=%0d want 0 1 0 0000 0",
                     done_b, busy_b, pass_b, mask_b, err_b);
        end
        start_b = 1'b0;
        mode_b = 2'd0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({done_b, busy_b, pass_b, mask_b, err_b} !== {3'b101, 4'd0, 4'd0}) begin
            n_err++;
            $display("FAIL b2b_second: got done=%b busy=%b pass=%b mask=%b err=%0d want 1 0 1 0000 0",
                     done_b, busy_b, pass_b, mask_b, err_b);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        mode_a = 2'd3;
        start_a = 1'b1;
        @(posedge clk); @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        // Vector 2 is driven now; vectors 0 and 1 have been scored.
        n_vec++;
        if ({busy_a, x1_a, x2_a, mask_a, err_a} !== {3'b101, 4'b0010, 4'd2}) begin
            n_err++;
            $display("FAIL midrun_live: got busy=%b x=%b%b mask=%b err=%0d want 1 01 0010 2",
                     busy_a, x1_a, x2_a, mask_a, err_a);
        end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if ({busy_a, done_a, pass_a, x1_a, x2_a, mask_a, err_a} !== 13'd0) begin
            n_err++;
            $display("FAIL midrun_reset: got busy=%b done=%b pass=%b x=%b%b mask=%b err=%0d want all 0",
                     busy_a, done_a, pass_a, x1_a, x2_a, mask_a, err_a);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_vec++;
            if (busy_a !== 1'b0 || done_a !== 1'b0) begin
                n_err++;
                $display("FAIL midrun_quiet cyc%0d: got busy=%b done=%b want 0 0", i, busy_a, done_a);
            end
        end
        test_good_run(1'b0, "post_reset_run");
    endtask

    initial begin
        test_reset();
        test_good_run(1'b0, "good_run");
        test_fault(2'd1, 4'b1000, 4'd1, 1'b0, "and_stuck0");
        test_fault(2'd2, 4'b0001, 4'd1, 1'b0, "or_stuck1");
        test_fault(2'd3, 4'b0110, 4'd4, 1'b0, "swapped");
        test_fault(2'd0, 4'b0000, 4'd0, 1'b1, "good_s1");
        test_good_run(1'b1, "start_in_run");
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
